// File: rtl/rf_wb_arbiter_pkg.sv
// Shared CPU constants and types for the register-file writeback arbiter slice.
package rf_wb_arbiter_pkg;

   localparam int REG_NUM = 32;
   localparam int REG_AW  = 5;
   localparam int DATA_W  = 32;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;
   typedef logic [1:0]        pend_cnt_t;

   localparam pend_cnt_t PEND_MAX = 2'd3;

   typedef struct packed {
      logic      we;
      reg_addr_t waddr;
      reg_data_t wdata;
   } rf_write_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Issue, writeback-request, register-file and operand-check signals of the arbiter.
interface rf_wb_arbiter_if;
   import rf_wb_arbiter_pkg::*;

   logic      issue_valid;
   reg_addr_t issue_waddr;
   logic      issue_ready;

   logic      req0_valid;
   logic      req0_ready;
   reg_addr_t req0_waddr;
   reg_data_t req0_wdata;

   logic      req1_valid;
   logic      req1_ready;
   reg_addr_t req1_waddr;
   reg_data_t req1_wdata;

   logic      rf_we;
   reg_addr_t rf_waddr;
   reg_data_t rf_wdata;

   reg_addr_t raddr1;
   reg_addr_t raddr2;
   logic      raw_stall;

   modport master (
      output issue_valid, issue_waddr,
      output req0_valid, req0_waddr, req0_wdata,
      output req1_valid, req1_waddr, req1_wdata,
      output raddr1, raddr2,
      input  issue_ready, req0_ready, req1_ready,
      input  rf_we, rf_waddr, rf_wdata, raw_stall
   );

   modport slave (
      input  issue_valid, issue_waddr,
      input  req0_valid, req0_waddr, req0_wdata,
      input  req1_valid, req1_waddr, req1_wdata,
      input  raddr1, raddr2,
      output issue_ready, req0_ready, req1_ready,
      output rf_we, rf_waddr, rf_wdata, raw_stall
   );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Per-register outstanding-write counters; gates issue and flags read-after-write hazards.
module rf_scoreboard
   import rf_wb_arbiter_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      issue_valid,
   input  reg_addr_t issue_waddr,
   output logic      issue_ready,
   input  logic      rf_we,
   input  reg_addr_t rf_waddr,
   input  reg_addr_t raddr1,
   input  reg_addr_t raddr2,
   output logic      raw_stall
);

   pend_cnt_t          pending [REG_NUM];
   logic [REG_NUM-1:0] inc_vec;
   logic [REG_NUM-1:0] dec_vec;

   assign issue_ready = (issue_waddr == '0) || (pending[issue_waddr] != PEND_MAX);

   assign raw_stall = ((raddr1 != '0) && (pending[raddr1] != '0)) ||
                      ((raddr2 != '0) && (pending[raddr2] != '0));

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (issue_valid && issue_ready && (issue_waddr != '0))
         inc_vec[issue_waddr] = 1'b1;
      if (rf_we && (rf_waddr != '0))
         dec_vec[rf_waddr] = 1'b1;
   end

   // A simultaneous issue and retire on one register cancel out; r0 is never tracked.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < REG_NUM; i++)
            pending[i] <= '0;
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            if (i == 0)
               pending[i] <= '0;
            else if (inc_vec[i] && !dec_vec[i])
               pending[i] <= pending[i] + 2'd1;
            else if (dec_vec[i] && !inc_vec[i] && (pending[i] != '0))
               pending[i] <= pending[i] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && rf_we && (rf_waddr != '0) && !inc_vec[rf_waddr])
         assert (pending[rf_waddr] != '0)
            else $error("rf_scoreboard: write-back to r%0d with no pending issue", rf_waddr);
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter with starvation guard and registered write port.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4
)
(
   input logic          clk,
   input logic          reset,
   rf_wb_arbiter_if.slave bus
);

   localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [STARVE_W-1:0] starve_cnt;
   logic                force1;
   logic                xfer0;
   logic                xfer1;
   reg_addr_t           win_addr;
   reg_data_t           win_data;
   rf_write_t           wr_q;

   // req0 normally wins; once req1 has waited STARVE_MAX cycles it takes the port.
   assign force1         = (starve_cnt >= STARVE_W'(STARVE_MAX));
   assign bus.req1_ready = bus.req1_valid && !(bus.req0_valid && !force1);
   assign bus.req0_ready = bus.req0_valid && !(bus.req1_valid && force1);
   assign xfer0          = bus.req0_valid && bus.req0_ready;
   assign xfer1          = bus.req1_valid && bus.req1_ready;

   always_ff @(posedge clk) begin
      if (reset)
         starve_cnt <= '0;
      else if (xfer1)
         starve_cnt <= '0;
      else if (bus.req1_valid && !bus.req1_ready && !force1)
         starve_cnt <= starve_cnt + 1'b1;
   end

   always_comb begin
      win_addr = bus.req0_waddr;
      win_data = bus.req0_wdata;
      if (xfer1) begin
         win_addr = bus.req1_waddr;
         win_data = bus.req1_wdata;
      end
   end

   // Writes to r0 are acknowledged but never reach the register file.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
      end else if (xfer0 || xfer1) begin
         wr_q.we    <= (win_addr != '0);
         wr_q.waddr <= win_addr;
         wr_q.wdata <= win_data;
      end else begin
         wr_q.we <= 1'b0;
      end
   end

   assign bus.rf_we    = wr_q.we;
   assign bus.rf_waddr = wr_q.waddr;
   assign bus.rf_wdata = wr_q.wdata;

   rf_scoreboard u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (bus.issue_valid),
      .issue_waddr (bus.issue_waddr),
      .issue_ready (bus.issue_ready),
      .rf_we       (wr_q.we),
      .rf_waddr    (wr_q.waddr),
      .raddr1      (bus.raddr1),
      .raddr2      (bus.raddr2),
      .raw_stall   (bus.raw_stall)
   );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scenarios followed by random traffic, checked every cycle against a behavioural model.
module tb_rf_wb_arbiter;
   import rf_wb_arbiter_pkg::*;

   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   rf_wb_arbiter_if bus();

   rf_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: outstanding writes per register, req1 waiting time, expected write port.
   int          pend [REG_NUM];
   int          wait1;
   bit          m_we;
   int          m_waddr;
   logic [31:0] m_wdata;
   bit          m_rst;
   int          winner;
   bit          exp_issue_ready;
   bit          exp_raw;
   bit          last_issue_acc;
   int          last_issue_reg;

   // Random-phase requester state.
   int          owed [REG_NUM];
   bit          r0_act, r1_act, do_rst;
   int          r0_addr, r1_addr;
   logic [31:0] r0_data, r1_data;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit iv, input int iw,
                                input bit v0, input int a0, input logic [31:0] d0,
                                input bit v1, input int a1, input logic [31:0] d1,
                                input int ra1, input int ra2);
      reset           = rst;
      bus.issue_valid = iv;
      bus.issue_waddr = reg_addr_t'(iw);
      bus.req0_valid  = v0;
      bus.req0_waddr  = reg_addr_t'(a0);
      bus.req0_wdata  = d0;
      bus.req1_valid  = v1;
      bus.req1_waddr  = reg_addr_t'(a1);
      bus.req1_wdata  = d1;
      bus.raddr1      = reg_addr_t'(ra1);
      bus.raddr2      = reg_addr_t'(ra2);
      #1;
   endtask

   task automatic idle(input int ra1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, ra1, 0);
   endtask

   task automatic predict();
      int ia, r1, r2;
      winner = -1;
      if (bus.req1_valid && wait1 >= STARVE_MAX) winner = 1;
      else if (bus.req0_valid)                   winner = 0;
      else if (bus.req1_valid)                   winner = 1;
      ia = int'(bus.issue_waddr);
      r1 = int'(bus.raddr1);
      r2 = int'(bus.raddr2);
      exp_issue_ready = (ia == 0) || (pend[ia] < 3);
      exp_raw = ((r1 != 0) && (pend[r1] > 0)) || ((r2 != 0) && (pend[r2] > 0));
   endtask

   task automatic updateModel();
      int addr;
      last_issue_acc = 0;
      if (reset) begin
         for (int i = 0; i < REG_NUM; i++) pend[i] = 0;
         wait1 = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_rst = 1;
      end else begin
         m_rst = 0;
         if (bus.issue_valid && exp_issue_ready && bus.issue_waddr != 0) begin
            pend[int'(bus.issue_waddr)]++;
            last_issue_acc = 1;
            last_issue_reg = int'(bus.issue_waddr);
         end
         if (m_we && pend[m_waddr] > 0) pend[m_waddr]--;
         if (winner == 1) wait1 = 0;
         else if (bus.req1_valid) wait1++;
         if (winner >= 0) begin
            addr    = (winner == 0) ? int'(bus.req0_waddr) : int'(bus.req1_waddr);
            m_wdata = (winner == 0) ? bus.req0_wdata : bus.req1_wdata;
            m_waddr = addr;
            m_we    = (addr != 0);
         end else begin
            m_we = 0;
         end
      end
   endtask

   task automatic stepCycle();
      predict();
      checkOutput("rf_we", bus.rf_we, m_we);
      if (m_we || m_rst) begin
         checkOutput("rf_waddr", bus.rf_waddr, m_waddr);
         checkOutput("rf_wdata", bus.rf_wdata, m_wdata);
      end
      checkOutput("issue_ready", bus.issue_ready, exp_issue_ready);
      checkOutput("raw_stall", bus.raw_stall, exp_raw);
      checkOutput("req0_ready", bus.req0_ready, winner == 0);
      checkOutput("req1_ready", bus.req1_ready, winner == 1);
      @(posedge clk);
      updateModel();
      #2;
   endtask

   task automatic pickWrite(output bit act, output int addr, output logic [31:0] data);
      int r;
      act  = 0;
      addr = 0;
      data = $urandom;
      if ($urandom_range(0, 4) == 0) begin
         act = 1;
      end else begin
         r = $urandom_range(1, 7);
         if (owed[r] > 0) begin
            owed[r]--;
            act  = 1;
            addr = r;
         end
      end
   endtask

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      updateModel();
      #2;
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      stepCycle();
      idle(0);
      checkOutput("rst_rf_we", bus.rf_we, 0);
      checkOutput("rst_issue_ready", bus.issue_ready, 1);
      checkOutput("rst_raw_stall", bus.raw_stall, 0);
      stepCycle();

      // Issue r5 and write it back through req0.
      applyStimulus(0, 1, 5, 0, 0, 0, 0, 0, 0, 5, 0);
      stepCycle();
      applyStimulus(0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 5, 0);
      checkOutput("r5_req0_ready", bus.req0_ready, 1);
      checkOutput("r5_raw_before", bus.raw_stall, 1);
      stepCycle();
      idle(5);
      checkOutput("r5_rf_we", bus.rf_we, 1);
      checkOutput("r5_rf_waddr", bus.rf_waddr, 5);
      checkOutput("r5_rf_wdata", bus.rf_wdata, 32'h1234);
      checkOutput("r5_raw_in_we", bus.raw_stall, 1);
      stepCycle();
      idle(5);
      checkOutput("r5_raw_after", bus.raw_stall, 0);
      stepCycle();

      // Simultaneous requests: req0 first, req1 the cycle after.
      applyStimulus(0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
      stepCycle();
      applyStimulus(0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0);
      stepCycle();
      applyStimulus(0, 0, 0, 1, 10, 32'hA, 1, 11, 32'hB, 10, 11);
      checkOutput("both_req0_ready", bus.req0_ready, 1);
      checkOutput("both_req1_ready", bus.req1_ready, 0);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 11, 32'hB, 10, 11);
      checkOutput("both_first_addr", bus.rf_waddr, 10);
      checkOutput("both_req1_late", bus.req1_ready, 1);
      stepCycle();
      idle(11);
      checkOutput("both_second_addr", bus.rf_waddr, 11);
      checkOutput("both_second_data", bus.rf_wdata, 32'hB);
      stepCycle();

      // Starvation: req0 busy every cycle, req1 forced in on its 5th waiting cycle.
      applyStimulus(0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0);
      stepCycle();
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(0, 0, 0, 1, 0, $urandom, 1, 12, 32'hC0DE, 12, 0);
         checkOutput("starve_req1_ready", bus.req1_ready, (k == 5));
         checkOutput("starve_req0_ready", bus.req0_ready, (k != 5));
         stepCycle();
      end
      idle(12);
      checkOutput("starve_rf_waddr", bus.rf_waddr, 12);
      stepCycle();

      // Write to r0 is acknowledged but suppressed.
      applyStimulus(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
      checkOutput("r0_req0_ready", bus.req0_ready, 1);
      checkOutput("r0_raw", bus.raw_stall, 0);
      stepCycle();
      idle(0);
      checkOutput("r0_rf_we", bus.rf_we, 0);
      stepCycle();

      // Saturate r7, then retire all three writes.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
         stepCycle();
      end
      applyStimulus(0, 1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
      checkOutput("r7_full", bus.issue_ready, 0);
      stepCycle();
      applyStimulus(0, 0, 0, 1, 7, 32'h70, 0, 0, 0, 7, 0);
      stepCycle();
      idle(7);
      stepCycle();
      applyStimulus(0, 0, 7, 0, 0, 0, 0, 0, 0, 7, 0);
      checkOutput("r7_ready_again", bus.issue_ready, 1);
      checkOutput("r7_raw_two_left", bus.raw_stall, 1);
      stepCycle();
      applyStimulus(0, 0, 0, 1, 7, 32'h71, 0, 0, 0, 7, 0);
      stepCycle();
      applyStimulus(0, 0, 0, 1, 7, 32'h72, 0, 0, 0, 7, 0);
      stepCycle();
      idle(7);
      checkOutput("r7_raw_last_we", bus.raw_stall, 1);
      stepCycle();
      idle(7);
      checkOutput("r7_raw_clear", bus.raw_stall, 0);
      stepCycle();

      // Reset with r3 pending and a req1 transfer in the reset cycle.
      applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, 3, 0);
      stepCycle();
      applyStimulus(0, 1, 4, 0, 0, 0, 0, 0, 0, 3, 4);
      stepCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 4, 32'h44, 3, 4);
      stepCycle();
      idle(3);
      checkOutput("midrst_rf_we", bus.rf_we, 0);
      checkOutput("midrst_raw", bus.raw_stall, 0);
      stepCycle();

      // Random traffic; writes only target registers with an accepted issue.
      for (int i = 0; i < REG_NUM; i++) owed[i] = 0;
      r0_act = 0;
      r1_act = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         do_rst = ($urandom_range(0, 199) == 0);
         if (!r0_act && $urandom_range(0, 2) != 0) pickWrite(r0_act, r0_addr, r0_data);
         if (!r1_act && $urandom_range(0, 2) != 0) pickWrite(r1_act, r1_addr, r1_data);
         applyStimulus(do_rst, bit'($urandom_range(0, 1)), $urandom_range(0, 7),
                       r0_act, r0_addr, r0_data, r1_act, r1_addr, r1_data,
                       $urandom_range(0, 7), $urandom_range(0, 7));
         stepCycle();
         if (winner == 0) r0_act = 0;
         if (winner == 1) r1_act = 0;
         if (last_issue_acc) owed[last_issue_reg]++;
         if (do_rst) begin
            r0_act = 0;
            r1_act = 0;
            for (int i = 0; i < REG_NUM; i++) owed[i] = 0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, consecutive req1 stall cycles before req1 is forced to win.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: issue_valid  input  1  decode issued an instruction that writes a register.
REQ-005 Port: issue_waddr  input  5  destination register of the issued instruction.
REQ-006 Port: issue_ready  output  1  low when the issue_waddr pending count is saturated.
REQ-007 Port: req0_valid / req0_ready  input / output  1 / 1  short-pipeline writeback handshake.
REQ-008 Port: req0_waddr / req0_wdata  input  5 / 32  short-pipeline writeback address and data.
REQ-009 Port: req1_valid / req1_ready  input / output  1 / 1  long-latency unit (div/load) writeback handshake.
REQ-010 Port: req1_waddr / req1_wdata  input  5 / 32  long-latency writeback address and data.
REQ-011 Port: rf_we / rf_waddr / rf_wdata  output  1 / 5 / 32  register-file write port drive.
REQ-012 Port: raddr1 / raddr2  input  5 / 5  decode source operands.
REQ-013 Port: raw_stall  output  1  a source operand has an outstanding write.

Function
REQ-014 Transfer on reqN: reqN_valid & reqN_ready in the same cycle; valid, waddr and wdata are held until the transfer.
REQ-015 req0 has fixed priority; req1_ready = req1_valid & ~(req0_valid & ~force1).
REQ-016 Starvation counter: +1 per cycle with req1_valid & ~req1_ready, cleared on req1 transfer; force1 = (counter >= STARVE_MAX).
REQ-017 With force1 set, req1 wins and req0_ready = 0 for that cycle.
REQ-018 At most one transfer per cycle; reqN_ready never depends on the same requester's wdata.
REQ-019 Output stage is registered: a transfer in cycle N gives rf_we=1 with that waddr/wdata in cycle N+1 only.
REQ-020 A transfer with waddr=0 is acknowledged, but rf_we stays 0 the next cycle.
REQ-021 Scoreboard: a 2-bit pending counter per register 1..31; register 0 has none and is never busy.
REQ-022 Counter +1 on issue_valid & issue_ready with a nonzero waddr.
REQ-023 Counter -1 on the cycle rf_we=1 for that waddr.
REQ-024 If an increment and a decrement hit the same register in one cycle, that counter is unchanged.
REQ-025 issue_ready = (pending[issue_waddr] != 3), or 1 when issue_waddr=0.
REQ-026 raw_stall = (raddr1 != 0 & pending[raddr1] != 0) | (raddr2 != 0 & pending[raddr2] != 0), combinational.
REQ-027 No bypass: raw_stall stays high in the rf_we cycle and falls the cycle after.
REQ-028 A decrement with the counter at 0 leaves it at 0; it is a protocol error and flagged by an assertion.

Reset
REQ-029 On reset=1 at a clock edge: rf_we=0, rf_waddr=0, rf_wdata=0, all pending counters=0, starvation counter=0.
REQ-030 Transfers in the reset cycle are discarded; after reset, req0_ready/req1_ready = their valid inputs, raw_stall=0, issue_ready=1.
REQ-031 Reset mid-operation drops all outstanding writes and scoreboard state with no rf_we pulse.

Structure
REQ-032 REG_NUM=32, REG_AW=5 and DATA_W=32 live in the shared CPU package/header.
REQ-033 The scoreboard is a separate sub-module rf_scoreboard (counters, issue_ready, raw_stall); the top holds arbitration and the output stage.

Verification
REQ-034 Issue r5, req0 writes r5=0x1234 -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 the next cycle; raw_stall for raddr1=5 drops the cycle after that.
REQ-035 req0 and req1 valid in the same cycle, once -> req0 is written first and req1 is written the following cycle.
REQ-036 req0 valid every cycle with req1 valid -> req1 is granted on its 5th waiting cycle (STARVE_MAX=4) and req0_ready=0 that cycle.
REQ-037 Issue r7 three times -> issue_ready=0 for r7; one write to r7 -> issue_ready=1 again and raw_stall stays 1 until all three are written.
REQ-038 req0 writes r0=0xFFFFFFFF -> req0_ready=1 and rf_we remains 0; raw_stall=0 for raddr=0.
REQ-039 Assert reset with r3 pending and a req1 transfer in flight -> rf_we=0 and raw_stall=0 the next cycle.
